// File: rtl/hls_run_pkg.sv
// Shared types for the HLS kernel run controller: FSM states, result status
// codes and the bit layout of a result word {run_idx, status, cycles}.
package hls_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KRST,
        S_START,
        S_WAIT,
        S_RECORD,
        S_STALL,
        S_FINISH
    } run_state_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_OK   = 2'b01,
        ST_TMO  = 2'b10,
        ST_ABT  = 2'b11
    } run_status_e;

    localparam int unsigned IDX_W    = 8;
    localparam int unsigned STATUS_W = 2;
    localparam int unsigned CYC_LSB  = 0;

    // Field offsets depend on the cycle-counter width chosen by the instance.
    function automatic int unsigned status_lsb(input int unsigned cnt_w);
        return cnt_w;
    endfunction

    function automatic int unsigned idx_lsb(input int unsigned cnt_w);
        return cnt_w + STATUS_W;
    endfunction

    function automatic int unsigned res_w(input int unsigned cnt_w);
        return cnt_w + STATUS_W + IDX_W;
    endfunction

endpackage

// File: rtl/hls_res_fifo.sv
// Result FIFO with valid/ready on both sides; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module hls_res_fifo #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_ready_c,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] pop_data_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q;
    logic             do_push, do_pop;

    assign do_pop       = valid_q && pop_ready_i;
    assign push_ready_c = (count_q != CNT_W'(DEPTH)) || do_pop;
    assign do_push      = push_i && push_ready_c;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_valid_o = valid_q;
    assign pop_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/hls_run_controller.sv
// Runs an HLS kernel N_RUNS times per batch: reset pulse, start pulse, wait for
// done/timeout/abort, and queue one {run_idx, status, cycles} result per run.
module hls_run_controller
    import hls_run_pkg::*;
#(
    parameter int unsigned N_RUNS     = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 200000000,
    parameter int unsigned RST_CYC    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            go,
    input  logic                            abort,
    output logic                            dut_reset,
    output logic                            dut_start,
    input  logic                            dut_done,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [IDX_W+STATUS_W+CNT_W-1:0] res_data,
    output logic                            busy,
    output logic                            batch_done
);

    localparam int unsigned RES_W  = res_w(CNT_W);
    localparam int unsigned RC_W   = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int unsigned ST_LSB = status_lsb(CNT_W);
    localparam int unsigned IX_LSB = idx_lsb(CNT_W);

    run_state_e       state_q, state_d;
    run_status_e      status_q, status_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d, cycles_inc;
    logic [IDX_W-1:0] run_idx_q, run_idx_d;
    logic             dut_reset_q, dut_start_q, busy_q, batch_done_q;
    logic             push_c, push_ready_c;
    logic [RES_W-1:0] res_word;

    assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);

    always_comb begin
        res_word = '0;
        res_word[IX_LSB  +: IDX_W]    = run_idx_q;
        res_word[ST_LSB  +: STATUS_W] = status_q;
        res_word[CYC_LSB +: CNT_W]    = cycles_q;
    end

    // Next state; cycles_q holds the value reported for the run once it ends.
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        rst_cnt_d = rst_cnt_q;
        cycles_d  = cycles_q;
        run_idx_d = run_idx_q;
        push_c    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    run_idx_d = '0;
                    rst_cnt_d = '0;
                    cycles_d  = '0;
                    state_d   = S_KRST;
                end
            end
            S_KRST: begin
                if (abort) begin
                    status_d = ST_ABT;
                    state_d  = S_RECORD;
                end else if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
                    cycles_d = CNT_W'(1);
                    state_d  = S_START;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            S_START: begin
                if (abort) begin
                    status_d = ST_ABT;
                    state_d  = S_RECORD;
                end else if (dut_done) begin
                    status_d = ST_OK;
                    state_d  = S_RECORD;
                end else begin
                    cycles_d = cycles_inc;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    status_d = ST_ABT;
                    state_d  = S_RECORD;
                end else if (dut_done) begin
                    status_d = ST_OK;
                    state_d  = S_RECORD;
                end else if (cycles_q >= CNT_W'(TIMEOUT)) begin
                    status_d = ST_TMO;
                    cycles_d = CNT_W'(TIMEOUT);
                    state_d  = S_RECORD;
                end else begin
                    cycles_d = cycles_inc;
                end
            end
            S_RECORD, S_STALL: begin
                if (push_ready_c) begin
                    push_c = 1'b1;
                    if (status_q == ST_ABT || run_idx_q == IDX_W'(N_RUNS - 1)) begin
                        state_d = S_FINISH;
                    end else begin
                        run_idx_d = run_idx_q + IDX_W'(1);
                        rst_cnt_d = '0;
                        cycles_d  = '0;
                        state_d   = S_KRST;
                    end
                end else begin
                    state_d = S_STALL;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Kernel-facing and status outputs are registered from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            status_q     <= ST_NONE;
            rst_cnt_q    <= '0;
            cycles_q     <= '0;
            run_idx_q    <= '0;
            dut_reset_q  <= 1'b0;
            dut_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            rst_cnt_q    <= rst_cnt_d;
            cycles_q     <= cycles_d;
            run_idx_q    <= run_idx_d;
            dut_reset_q  <= (state_d != S_KRST);
            dut_start_q  <= (state_d == S_START);
            busy_q       <= (state_d != S_IDLE);
            batch_done_q <= (state_d == S_FINISH);
        end
    end

    assign dut_reset  = dut_reset_q;
    assign dut_start  = dut_start_q;
    assign busy       = busy_q;
    assign batch_done = batch_done_q;

    hls_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push_c),
        .push_data_i  (res_word),
        .push_ready_c (push_ready_c),
        .pop_valid_o  (res_valid),
        .pop_ready_i  (res_ready),
        .pop_data_o   (res_data)
    );

endmodule

// File: tb/tb_hls_run_controller.sv
// Bench for hls_run_controller: instance 0 (3 runs, depth 4) and instance 1
// (4 runs, depth 2), both with TIMEOUT=50 and a 16-bit cycle counter.
module tb_hls_run_controller;

    localparam int unsigned CW  = 16;
    localparam int unsigned DW  = 8 + 2 + CW;
    localparam int          TMO = 50;

    logic clock = 1'b0;
    logic reset;
    logic [1:0] go_v, abort_v, done_v, ready_v;
    logic [1:0] dres_v, dstart_v, valid_v, busy_v, bd_v;
    logic [DW-1:0] data_v [2];

    always #5 clock = ~clock;

    hls_run_controller #(
        .N_RUNS(3), .CNT_W(CW), .TIMEOUT(TMO), .RST_CYC(2), .FIFO_DEPTH(4)
    ) dut0 (
        .clock(clock), .reset(reset), .go(go_v[0]), .abort(abort_v[0]),
        .dut_reset(dres_v[0]), .dut_start(dstart_v[0]), .dut_done(done_v[0]),
        .res_valid(valid_v[0]), .res_ready(ready_v[0]), .res_data(data_v[0]),
        .busy(busy_v[0]), .batch_done(bd_v[0])
    );

    hls_run_controller #(
        .N_RUNS(4), .CNT_W(CW), .TIMEOUT(TMO), .RST_CYC(2), .FIFO_DEPTH(2)
    ) dut1 (
        .clock(clock), .reset(reset), .go(go_v[1]), .abort(abort_v[1]),
        .dut_reset(dres_v[1]), .dut_start(dstart_v[1]), .dut_done(done_v[1]),
        .res_valid(valid_v[1]), .res_ready(ready_v[1]), .res_data(data_v[1]),
        .busy(busy_v[1]), .batch_done(bd_v[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Kernel behaviour per instance: done in the cycle whose start-relative
    // count (start cycle = 1) equals lat; lat 0 means the kernel never finishes.
    int lat_arr [2][8];
    int abort_run [2];
    int abort_at [2];
    int k [2];
    int cur_run [2];
    int starts [2];
    int krst_n [2];
    int bd_cnt [2];
    bit hold [2];
    logic [DW-1:0] hold_data [2];
    logic [DW-1:0] got0 [$];
    logic [DW-1:0] got1 [$];
    logic [63:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] mk(input int r, input int st, input int c);
        logic [DW-1:0] w;
        w = {8'(r), 2'(st), CW'(c)};
        return 64'(w);
    endfunction

    function automatic logic [63:0] get_got(input int inst, input int j);
        if (inst == 0) return (j < got0.size()) ? 64'(got0[j]) : 64'hFFFF_FFFF_FFFF_FFFF;
        return (j < got1.size()) ? 64'(got1[j]) : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic int got_size(input int inst);
        return (inst == 0) ? got0.size() : got1.size();
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    k[i]    = 0;
                    hold[i] = 1'b0;
                end else begin
                    if (!dres_v[i]) begin
                        k[i] = 0;
                        krst_n[i]++;
                    end else if (dstart_v[i]) begin
                        k[i]       = 1;
                        cur_run[i] = starts[i] & 7;
                        starts[i]++;
                    end else if (k[i] > 0) begin
                        k[i]++;
                    end
                    if (bd_v[i]) bd_cnt[i]++;
                    if (hold[i]) begin
                        chk("hold_valid", 64'(valid_v[i]), 64'd1);
                        chk("hold_data", 64'(data_v[i]), 64'(hold_data[i]));
                    end
                    if (valid_v[i] && ready_v[i]) begin
                        if (i == 0) got0.push_back(data_v[i]);
                        else        got1.push_back(data_v[i]);
                    end
                    hold[i]      = valid_v[i] && !ready_v[i];
                    hold_data[i] = data_v[i];
                end
                done_v[i]  = (k[i] != 0) && (k[i] == lat_arr[i][cur_run[i]]);
                abort_v[i] = (k[i] != 0) && (cur_run[i] == abort_run[i]) && (k[i] == abort_at[i]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        starts = '{0, 0};
        krst_n = '{0, 0};
        bd_cnt = '{0, 0};
        got0.delete();
        got1.delete();
    endtask

    // Pulse go, wait (bounded) for batch_done, then drain the FIFO.
    task automatic run_batch(input int inst, input bit ready_rand);
        int budget;
        clear_obs();
        if (!ready_rand) ready_v[inst] = 1'b1;
        go_v[inst] = 1'b1;
        tick(1);
        go_v[inst] = 1'b0;
        budget = 3000;
        while (bd_cnt[inst] == 0 && budget > 0) begin
            if (ready_rand) ready_v[inst] = ($urandom_range(0, 3) != 0);
            tick(1);
            budget--;
        end
        if (budget == 0) chk("batch_done_timeout", 64'(bd_cnt[inst]), 64'd1);
        ready_v[inst] = 1'b1;
        tick(8);
    endtask

    // Expected results for instance 0 from the run rules: abort beats done
    // beats timeout, and an abort ends the batch.
    task automatic build_expected(input int n_runs);
        exp_q.delete();
        for (int r = 0; r < n_runs; r++) begin
            int fin;
            int st;
            if (lat_arr[0][r] != 0 && lat_arr[0][r] <= TMO) begin
                fin = lat_arr[0][r];
                st  = 1;
            end else begin
                fin = TMO;
                st  = 2;
            end
            if (r == abort_run[0] && abort_at[0] >= 1 && abort_at[0] <= fin) begin
                exp_q.push_back(mk(r, 3, abort_at[0]));
                break;
            end
            exp_q.push_back(mk(r, st, fin));
        end
    endtask

    typedef struct {
        int lat;
        int ab_run;
        int ab_at;
        int exp_n;
        int exp_st;
        int exp_cyc;
        int last_st;
        int last_cyc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{10, -1, 0, 3, 1, 10, 1, 10};
        vecs[1] = '{1,  -1, 0, 3, 1, 1,  1, 1};
        vecs[2] = '{0,  -1, 0, 3, 2, 50, 2, 50};
        vecs[3] = '{50, -1, 0, 3, 1, 50, 1, 50};
        vecs[4] = '{51, -1, 0, 3, 2, 50, 2, 50};
        vecs[5] = '{20,  1, 7, 2, 1, 20, 3, 7};
        vecs[6] = '{5,   0, 5, 1, 1, 5,  3, 5};
        vecs[7] = '{2,   2, 1, 3, 1, 2,  3, 1};

        go_v = '0; ready_v = '0; abort_run = '{-1, -1}; abort_at = '{0, 0};
        cur_run = '{0, 0}; k = '{0, 0};
        for (int i = 0; i < 2; i++) for (int r = 0; r < 8; r++) lat_arr[i][r] = 0;
        clear_obs();
        reset = 1'b1;
        #2 reset = 1'b0;
        tick(2);
        chk("rst_dut_reset", 64'(dres_v), 64'd0);
        chk("rst_dut_start", 64'(dstart_v), 64'd0);
        chk("rst_res_valid", 64'(valid_v), 64'd0);
        chk("rst_busy", 64'(busy_v), 64'd0);
        chk("rst_batch_done", 64'(bd_v), 64'd0);
        reset = 1'b1;
        tick(1);
        chk("post_rst_dut_reset", 64'(dres_v), 64'd3);
        chk("post_rst_busy", 64'(busy_v), 64'd0);

        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < 8; r++) lat_arr[0][r] = vecs[v].lat;
            abort_run[0] = vecs[v].ab_run;
            abort_at[0]  = vecs[v].ab_at;
            run_batch(0, 1'b0);
            chk($sformatf("v%0d_count", v), 64'(got0.size()), 64'(vecs[v].exp_n));
            for (int j = 0; j < vecs[v].exp_n; j++) begin
                if (j == vecs[v].exp_n - 1)
                    chk($sformatf("v%0d_res%0d", v, j), get_got(0, j),
                        mk(j, vecs[v].last_st, vecs[v].last_cyc));
                else
                    chk($sformatf("v%0d_res%0d", v, j), get_got(0, j),
                        mk(j, vecs[v].exp_st, vecs[v].exp_cyc));
            end
            chk($sformatf("v%0d_batch_done", v), 64'(bd_cnt[0]), 64'd1);
            chk($sformatf("v%0d_starts", v), 64'(starts[0]), 64'(vecs[v].exp_n));
            chk($sformatf("v%0d_krst_cycles", v), 64'(krst_n[0]), 64'(2 * vecs[v].exp_n));
            chk($sformatf("v%0d_idle", v), 64'(busy_v[0]), 64'd0);
        end
        abort_run[0] = -1;

        // Depth-2 FIFO with the consumer stalled: two pushes, then hold in STALL.
        for (int r = 0; r < 8; r++) lat_arr[1][r] = 3;
        clear_obs();
        ready_v[1] = 1'b0;
        go_v[1] = 1'b1;
        tick(1);
        go_v[1] = 1'b0;
        tick(80);
        chk("stall_no_pop", 64'(got1.size()), 64'd0);
        chk("stall_valid", 64'(valid_v[1]), 64'd1);
        chk("stall_head", 64'(data_v[1]), mk(0, 1, 3));
        chk("stall_busy", 64'(busy_v[1]), 64'd1);
        chk("stall_starts", 64'(starts[1]), 64'd3);
        tick(20);
        chk("stall_holds", 64'(starts[1]), 64'd3);
        chk("stall_no_batch_done", 64'(bd_cnt[1]), 64'd0);
        ready_v[1] = 1'b1;
        begin
            int budget;
            budget = 500;
            while (bd_cnt[1] == 0 && budget > 0) begin
                tick(1);
                budget--;
            end
        end
        tick(8);
        chk("stall_batch_done", 64'(bd_cnt[1]), 64'd1);
        chk("stall_count", 64'(got1.size()), 64'd4);
        for (int j = 0; j < 4; j++) chk($sformatf("stall_res%0d", j), get_got(1, j), mk(j, 1, 3));

        // Reset in the middle of run 1's WAIT with run 0's result still queued.
        lat_arr[0][0] = 4; lat_arr[0][1] = 0; lat_arr[0][2] = 0;
        clear_obs();
        ready_v[0] = 1'b0;
        go_v[0] = 1'b1;
        tick(1);
        go_v[0] = 1'b0;
        begin
            int budget;
            budget = 200;
            while (starts[0] < 2 && budget > 0) begin
                tick(1);
                budget--;
            end
            if (budget == 0) chk("mid_reset_reach_run1", 64'(starts[0]), 64'd2);
        end
        tick(5);
        chk("pre_reset_valid", 64'(valid_v[0]), 64'd1);
        chk("pre_reset_busy", 64'(busy_v[0]), 64'd1);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("async_dut_reset", 64'(dres_v[0]), 64'd0);
        chk("async_dut_start", 64'(dstart_v[0]), 64'd0);
        chk("async_res_valid", 64'(valid_v[0]), 64'd0);
        chk("async_busy", 64'(busy_v[0]), 64'd0);
        chk("async_batch_done", 64'(bd_v[0]), 64'd0);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rerun_dut_reset", 64'(dres_v[0]), 64'd1);
        chk("rerun_fifo_empty", 64'(valid_v[0]), 64'd0);
        ready_v[0] = 1'b1;
        tick(20);
        chk("no_result_after_reset", 64'(got0.size()), 64'd0);
        chk("no_batch_done_after_reset", 64'(bd_cnt[0]), 64'd0);

        // Randomized batches against the rule-based model.
        for (int b = 0; b < 40; b++) begin
            for (int r = 0; r < 3; r++)
                lat_arr[0][r] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 60));
            if ($urandom_range(0, 2) == 0) begin
                abort_run[0] = int'($urandom_range(0, 2));
                abort_at[0]  = int'($urandom_range(1, 60));
            end else begin
                abort_run[0] = -1;
            end
            build_expected(3);
            run_batch(0, 1'b1);
            chk($sformatf("rnd%0d_count", b), 64'(got_size(0)), 64'(exp_q.size()));
            for (int j = 0; j < exp_q.size(); j++)
                chk($sformatf("rnd%0d_res%0d", b, j), get_got(0, j), exp_q[j]);
            chk($sformatf("rnd%0d_batch_done", b), 64'(bd_cnt[0]), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
